// File: rtl/mem_fifo_pkg.sv
// mem_fifo_pkg: shared state encoding and FIFO geometry defaults for the memory FIFO read path.
package mem_fifo_pkg;
  localparam int WIDTH_DEF = 64;
  localparam int DEPTH_DEF = 6;
  typedef enum logic {IDLE, BURST} state_t;
endpackage

// File: rtl/mem_fifo_skid2.sv
// mem_fifo_skid2: two-entry skid buffer with push/pop, occupancy count and head data.
module mem_fifo_skid2
  import mem_fifo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       cnt
);
  logic [WIDTH-1:0] mem0_q, mem0_d, mem1_q, mem1_d;
  logic             wp_q, wp_d, rp_q, rp_d;
  logic [1:0]       cnt_q, cnt_d;
  always_comb begin
    mem0_d = (push && !wp_q) ? push_data : mem0_q;
    mem1_d = (push && wp_q) ? push_data : mem1_q;
    wp_d   = wp_q ^ push;
    rp_d   = rp_q ^ pop;
    cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem0_q <= '0;
      mem1_q <= '0;
      wp_q   <= 1'b0;
      rp_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      mem0_q <= mem0_d;
      mem1_q <= mem1_d;
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      cnt_q  <= cnt_d;
    end
  end
  assign head = rp_q ? mem1_q : mem0_q;
  assign cnt  = cnt_q;
endmodule

// File: rtl/mem_fifo_drain.sv
// mem_fifo_drain: pops the memory FIFO in bursts and streams the words out through a skid buffer.
module mem_fifo_drain
  import mem_fifo_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int BURST_LEN = 8
) (
  input  logic             clk,
  input  logic             reset,
  output logic             fifo_rd,
  input  logic             fifo_empty,
  input  logic [DEPTH:0]   fifo_space,
  input  logic [WIDTH-1:0] fifo_r_data,
  input  logic             fifo_r_data_valid,
  input  logic             flush,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic             busy,
  output logic             err_unexp
);
  localparam logic [DEPTH:0] CAP = (DEPTH+1)'(2**DEPTH);
  localparam logic [DEPTH:0] BL  = (DEPTH+1)'(BURST_LEN);
  localparam logic [DEPTH:0] ONE = (DEPTH+1)'(1);
  state_t         state_q, state_d;
  logic [DEPTH:0] blen_q, blen_d, issued_q, issued_d, sent_q, sent_d, occ;
  logic           inflight_q, inflight_d, err_q, err_d;
  logic           skid_push, xfer;
  logic [1:0]     skid_cnt;
  mem_fifo_skid2 #(.WIDTH(WIDTH)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .push      (skid_push),
    .push_data (fifo_r_data),
    .pop       (xfer),
    .head      (m_data),
    .cnt       (skid_cnt)
  );
  always_comb begin
    occ       = CAP - fifo_space;
    m_valid   = skid_cnt != 2'd0;
    xfer      = m_valid && m_ready;
    m_last    = m_valid && (sent_q == blen_q - ONE);
    // Room is judged after this cycle's pop so a steady stream reads every cycle.
    fifo_rd   = (state_q == BURST) && !fifo_empty && (issued_q < blen_q) &&
                (({1'b0, skid_cnt} - {2'b0, xfer} + {2'b0, inflight_q}) < 3'd2);
    skid_push = fifo_r_data_valid && inflight_q;
    err_d     = err_q | (fifo_r_data_valid && !inflight_q);
    inflight_d = fifo_rd;
    issued_d  = issued_q + (fifo_rd ? ONE : '0);
    sent_d    = sent_q + (xfer ? ONE : '0);
    state_d   = state_q;
    blen_d    = blen_q;
    if (state_q == IDLE) begin
      state_d = (occ >= BL || (flush && !fifo_empty)) ? BURST : IDLE;
      blen_d  = (occ >= BL) ? BL : ((flush && !fifo_empty) ? occ : blen_q);
    end else if (xfer && m_last) begin
      state_d  = IDLE;
      issued_d = '0;
      sent_d   = '0;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      blen_q     <= '0;
      issued_q   <= '0;
      sent_q     <= '0;
      inflight_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      blen_q     <= blen_d;
      issued_q   <= issued_d;
      sent_q     <= sent_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end
  assign busy      = state_q != IDLE;
  assign err_unexp = err_q;
endmodule
